imem_loader: RTL and testbench

Boot sequencer for the pipelined CPU. Holds the core in reset, receives program words as a byte stream over a valid/ready handshake, writes them into instruction memory from address 0 upward, then releases the core.

It sits between the board-level byte source, the instruction-memory write port and the CPU `rst_n_i` input. It is the only agent that writes instruction memory.

---
 rtl/imem_loader.sv | 211 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: holds the CPU in reset, streams big-endian words into instruction memory, then releases it.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 7,
  parameter int WIDTH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [WIDTH-1:0]  imem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int BYTES = WIDTH / 8;
  localparam int BC_W  = $clog2(BYTES);
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WR   = 3'd2,
    ST_RUN  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    ST_CHK  = 3'd4,
    ST_ERR  = 3'd5
`endif
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   last_addr_r;
  logic [BC_W-1:0]     byte_cnt_r;
  logic [WIDTH-9:0]    word_r;
  logic                ready_r;
  logic                we_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [WIDTH-1:0]    wdata_r;
  logic                cpu_run_r;
  logic                busy_r;
  logic                done_r;
  logic [ADDR_W:0]     cnt_s;
  logic [ADDR_W-1:0]   last_s;
  logic                zero_s;
  logic                start_ok_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_r;
  logic                error_r;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction
`endif

  // Clamp the requested count, derive the last address and decide whether start is honoured
  always_comb begin
    cnt_s      = word_count_i;
    start_ok_s = 1'b0;
    if (word_count_i > MAX_COUNT) begin
      cnt_s = MAX_COUNT;
    end else begin
      cnt_s = word_count_i;
    end
    zero_s = (cnt_s == {(ADDR_W+1){1'b0}});
    last_s = ADDR_W'(cnt_s - {{ADDR_W{1'b0}}, 1'b1});
    case (state_r)
      ST_IDLE, ST_RUN: start_ok_s = start_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_ERR:          start_ok_s = start_i;
`endif
      default:         start_ok_s = 1'b0;
    endcase
  end

  // Load sequencer; every output is registered and set for the state being entered
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      last_addr_r <= {ADDR_W{1'b0}};
      byte_cnt_r  <= {BC_W{1'b0}};
      word_r      <= {(WIDTH-8){1'b0}};
      ready_r     <= 1'b0;
      we_r        <= 1'b0;
      waddr_r     <= {ADDR_W{1'b0}};
      wdata_r     <= {WIDTH{1'b0}};
      cpu_run_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r      <= 8'h00;
      error_r     <= 1'b0;
`endif
    end else if (start_ok_s) begin
      addr_r      <= {ADDR_W{1'b0}};
      last_addr_r <= last_s;
      byte_cnt_r  <= {BC_W{1'b0}};
      we_r        <= 1'b0;
      waddr_r     <= {ADDR_W{1'b0}};
      wdata_r     <= {WIDTH{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r      <= 8'h00;
      error_r     <= 1'b0;
`endif
      if (zero_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_r   <= ST_CHK;
        ready_r   <= 1'b1;
        busy_r    <= 1'b1;
        cpu_run_r <= 1'b0;
        done_r    <= 1'b0;
`else
        state_r   <= ST_RUN;
        ready_r   <= 1'b0;
        busy_r    <= 1'b0;
        cpu_run_r <= 1'b1;
        done_r    <= 1'b1;
`endif
      end else begin
        state_r   <= ST_LOAD;
        ready_r   <= 1'b1;
        busy_r    <= 1'b1;
        cpu_run_r <= 1'b0;
        done_r    <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (byte_valid_i && ready_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r <= csum_update(csum_r, byte_i);
`endif
            if (byte_cnt_r == LAST_BYTE) begin
              byte_cnt_r <= {BC_W{1'b0}};
              state_r    <= ST_WR;
              ready_r    <= 1'b0;
              we_r       <= 1'b1;
              waddr_r    <= addr_r;
              wdata_r    <= {word_r, byte_i};
            end else begin
              byte_cnt_r <= byte_cnt_r + BC_W'(1'b1);
              word_r     <= {word_r[WIDTH-17:0], byte_i};
            end
          end
        end
        ST_WR: begin
          we_r    <= 1'b0;
          waddr_r <= {ADDR_W{1'b0}};
          wdata_r <= {WIDTH{1'b0}};
          if (addr_r == last_addr_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_r   <= ST_CHK;
            ready_r   <= 1'b1;
`else
            state_r   <= ST_RUN;
            busy_r    <= 1'b0;
            cpu_run_r <= 1'b1;
            done_r    <= 1'b1;
`endif
          end else begin
            addr_r  <= addr_r + ADDR_W'(1'b1);
            state_r <= ST_LOAD;
            ready_r <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (byte_valid_i && ready_r) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            if (byte_i == csum_r) begin
              state_r   <= ST_RUN;
              cpu_run_r <= 1'b1;
              done_r    <= 1'b1;
            end else begin
              state_r   <= ST_ERR;
              error_r   <= 1'b1;
            end
          end
        end
`endif
        default: state_r <= state_r;
      endcase
    end
  end

  assign byte_ready_o = ready_r;
  assign imem_we_o    = we_r;
  assign imem_addr_o  = waddr_r;
  assign imem_wdata_o = wdata_r;
  assign cpu_rst_n_o  = cpu_run_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error_o      = error_r;
`else
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a negedge monitor pops and compares.
module tb_imem_loader;
  localparam int ADDR_W = 7;
  localparam int WIDTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [WIDTH-1:0]  imem_wdata_o;
  logic              cpu_rst_n_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] csum;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .word_count_i (word_count),
    .byte_valid_i (byte_valid),
    .byte_i       (byte_data),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_rst_n_o  (cpu_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard; idle write port must be zero
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (imem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr_o, imem_wdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(imem_addr_o), 64'(mon_e.addr));
          check("wr_data", 64'(imem_wdata_o), 64'(mon_e.data));
          check("ready_low_in_wr", 64'(byte_ready_o), 64'(0));
        end
      end else begin
        check("idle_port_zero", 64'({imem_addr_o, imem_wdata_o}), 64'(0));
      end
    end
  end

  function automatic logic [31:0] pat(input int i);
    logic [7:0] a;
    a = i[7:0];
    return {a, a ^ 8'h5A, ~a, 8'h3C};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   t;
    logic acc;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t   = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = byte_ready_o;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    byte_valid = 1'b0;
    csum = csum ^ b;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got ready 0 expected 1 within 50 cycles for byte %0h", b);
    end
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input int gap);
    exp_q.push_back({addr[ADDR_W-1:0], w});
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], gap);
  endtask

  task automatic do_start(input int c);
    csum       = 8'h00;
    word_count = c[ADDR_W:0];
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("start_latency", 64'({byte_ready_o, cpu_rst_n_o, done_o}), 64'(3'b100));
`else
    if (c == 0) check("zero_count_run", 64'({byte_ready_o, cpu_rst_n_o, done_o}), 64'(3'b011));
    else        check("start_latency", 64'({byte_ready_o, cpu_rst_n_o, done_o}), 64'(3'b100));
`endif
    @(posedge clk);
    #1;
  endtask

  // Entered in the final WR cycle (or right after start for a zero count)
  task automatic expect_run(input string name);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = csum;
    send_byte(c, 0);
    @(negedge clk);
`else
    @(negedge clk);
    @(negedge clk);
`endif
    check(name, 64'({cpu_rst_n_o, done_o, busy_o, error_o}), 64'(4'b1100));
    check("all_writes_seen", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300us");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = 8'h00; csum = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({byte_ready_o, imem_we_o, cpu_rst_n_o, busy_o, done_o, error_o}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back two-word load
    do_start(2);
    send_word(0, 32'h12345678, 0);
    send_word(1, 32'h9ABCDEF0, 0);
    expect_run("b2b_run");

    // Restart from RUN with a bubbled stream
    do_start(2);
    send_word(0, 32'h12345678, 3);
    send_word(1, 32'h9ABCDEF0, 3);
    expect_run("bubbled_run");

    // Start pulsed mid-load must be ignored
    do_start(1);
    exp_q.push_back({{ADDR_W{1'b0}}, 32'h0BADF00D});
    send_byte(8'h0B, 0);
    send_byte(8'hAD, 0);
    word_count = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'hF0, 0);
    send_byte(8'h0D, 0);
    expect_run("ignored_start_run");

    // Zero count
    do_start(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
    @(negedge clk);
    check("zero_count_chk_run", 64'({cpu_rst_n_o, done_o}), 64'(2'b11));
    @(posedge clk);
    #1;
`endif

    // Count above 2^ADDR_W clamps to 128 words
    do_start(200);
    for (int i = 0; i < 128; i++) send_word(i, pat(i), 0);
    expect_run("clamp_run");

    // Reset part-way through the first word
    do_start(2);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midload_reset", 64'({byte_ready_o, imem_we_o, cpu_rst_n_o, busy_o, done_o, error_o, imem_addr_o, imem_wdata_o}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(1);
    send_word(0, 32'hCAFEF00D, 0);
    expect_run("reload_run");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum leaves the CPU in reset with error set, then a clean restart
    do_start(1);
    send_word(0, 32'h12345678, 0);
    send_byte(8'h09, 0);
    @(negedge clk);
    check("chk_err", 64'({error_o, cpu_rst_n_o, done_o}), 64'(3'b100));
    @(posedge clk);
    #1;
    do_start(1);
    send_word(0, 32'h12345678, 0);
    check("csum_value", 64'(csum), 64'(8'h08));
    expect_run("chk_ok_run");
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
